vga_fetch_sched: RTL and testbench

VGA_FETCH_SCHED -- requirements
Module: vga_fetch_sched

---
 rtl/vga_fetch_sched_pkg.sv | 20 ++
 rtl/vga_fetch_sched.sv | 206 ++++++++++++++++++++
 tb/tb_vga_fetch_sched.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_fetch_sched_pkg.sv
// Shared definitions for the VGA text-mode fetch scheduler: FSM encoding and
// the line-graphics code range that enables the ninth-column copy.
package vga_fetch_sched_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StTxt  = 2'd1,
      StFnt  = 2'd2,
      StCpu  = 2'd3
   } vga_state_e;

   localparam logic [7:0] LineGfxFirst = 8'hC0;
   localparam logic [7:0] LineGfxLast  = 8'hDF;

   // Box-drawing codes extend their rightmost pixel into the ninth column.
   function automatic logic is_line_gfx(input logic [7:0] code);
      return (code >= LineGfxFirst) && (code <= LineGfxLast);
   endfunction

endpackage

// File: rtl/vga_fetch_sched.sv
// Video memory arbiter for a text-mode VGA pipeline. Each character period it
// fetches a text cell and its font row, presents the result one period later,
// and fills idle memory slots with CPU accesses.
module vga_fetch_sched
   import vga_fetch_sched_pkg::*;
#(
   parameter int unsigned       ADDR_W    = 16,
   parameter logic [ADDR_W-1:0] FONT_BASE = 16'hC000
) (
   input  logic              clock_i,
   input  logic              reset_ni,
   input  logic              mode8_i,
   input  logic              char_stb_i,
   input  logic              active_i,
   input  logic [ADDR_W-1:0] text_addr_i,
   input  logic [3:0]        row_i,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic              mem_we_o,
   output logic [15:0]       mem_wdata_o,
   input  logic              mem_ack_i,
   input  logic [15:0]       mem_rdata_i,
   input  logic              cpu_req_i,
   input  logic              cpu_we_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [15:0]       cpu_wdata_i,
   output logic              cpu_ack_o,
   output logic [15:0]       cpu_rdata_o,
   output logic [7:0]        glyph_o,
   output logic [7:0]        attr_o,
   output logic              col9_o,
   output logic              glyph_vld_o,
   output logic              underrun_o,
   input  logic              underrun_clr_i
);

   vga_state_e        state_q, state_d;
   logic              pend_q, pend_d;         // video fetch wanted, not yet started
   logic              stale_q, stale_d;       // in-flight video request was abandoned
   logic              done_q, done_d;         // this period's fetch completed
   logic              prev_act_q, prev_act_d; // last strobe was in the active region
   logic [ADDR_W-1:0] vaddr_q;
   logic [3:0]        row_q;
   logic [7:0]        code_q, fattr_q, fglyph_q;
   logic [7:0]        glyph_out_q, attr_out_q;
   logic              col9_out_q, vld_out_q;
   logic              underrun_q, underrun_d;
   logic              cpu_ack_q;
   logic [15:0]       cpu_rdata_q;

   logic              in_video;
   logic              discard;
   logic              show;
   logic              urun_set;
   logic [ADDR_W-1:0] font_addr;

   assign in_video  = (state_q == StTxt) || (state_q == StFnt);
   // A strobe in the ack cycle makes the returning data belong to a dead period.
   assign discard   = stale_q || char_stb_i;
   assign show      = active_i && prev_act_q && done_q;
   assign urun_set  = char_stb_i && active_i && prev_act_q && !done_q;
   assign font_addr = FONT_BASE + ADDR_W'({code_q, row_q});

   // Next-state logic: video first, CPU only when no video is pending or arriving.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (pend_q && !char_stb_i) begin
               state_d = StTxt;
            end else if (!pend_q && !(char_stb_i && active_i) && cpu_req_i && !cpu_ack_q) begin
               state_d = StCpu;
            end
         end
         StTxt: if (mem_ack_i) state_d = discard ? StIdle : StFnt;
         StFnt: if (mem_ack_i) state_d = StIdle;
         StCpu: if (mem_ack_i) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Video bookkeeping flags; a strobe always starts a fresh period.
   always_comb begin
      pend_d     = pend_q;
      stale_d    = stale_q;
      done_d     = done_q;
      prev_act_d = prev_act_q;
      underrun_d = underrun_q;
      if (state_q == StIdle && pend_q && !char_stb_i) pend_d = 1'b0;
      if (in_video && mem_ack_i) begin
         stale_d = 1'b0;
      end else if (char_stb_i && in_video) begin
         stale_d = 1'b1;
      end
      if (state_q == StFnt && mem_ack_i && !discard) done_d = 1'b1;
      if (char_stb_i) begin
         pend_d     = active_i;
         done_d     = 1'b0;
         prev_act_d = active_i;
      end
      if (underrun_clr_i) underrun_d = 1'b0;
      if (urun_set) underrun_d = 1'b1;
   end

   // Memory port is a pure function of state so it holds steady until ack.
   always_comb begin
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      unique case (state_q)
         StTxt: begin
            mem_req_o  = 1'b1;
            mem_addr_o = vaddr_q;
         end
         StFnt: begin
            mem_req_o  = 1'b1;
            mem_addr_o = font_addr;
         end
         StCpu: begin
            mem_req_o   = 1'b1;
            mem_we_o    = cpu_we_i;
            mem_addr_o  = cpu_addr_i;
            mem_wdata_o = cpu_wdata_i;
         end
         default: ;
      endcase
   end

   // Control state and flags.
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q    <= StIdle;
         pend_q     <= 1'b0;
         stale_q    <= 1'b0;
         done_q     <= 1'b0;
         prev_act_q <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pend_q     <= pend_d;
         stale_q    <= stale_d;
         done_q     <= done_d;
         prev_act_q <= prev_act_d;
         underrun_q <= underrun_d;
      end
   end

   // Request latch and fetched cell/font data.
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         vaddr_q  <= '0;
         row_q    <= '0;
         code_q   <= '0;
         fattr_q  <= '0;
         fglyph_q <= '0;
      end else begin
         if (char_stb_i && active_i) begin
            vaddr_q <= text_addr_i;
            row_q   <= row_i;
         end
         if (state_q == StTxt && mem_ack_i && !discard) begin
            code_q  <= mem_rdata_i[7:0];
            fattr_q <= mem_rdata_i[15:8];
         end
         if (state_q == StFnt && mem_ack_i && !discard) fglyph_q <= mem_rdata_i[7:0];
      end
   end

   // Output stage: present the previous period's result, or blank.
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         glyph_out_q <= '0;
         attr_out_q  <= '0;
         col9_out_q  <= 1'b0;
         vld_out_q   <= 1'b0;
      end else begin
         vld_out_q <= char_stb_i;
         if (char_stb_i) begin
            glyph_out_q <= show ? fglyph_q : 8'h00;
            attr_out_q  <= show ? fattr_q : 8'h00;
            col9_out_q  <= show && !mode8_i && is_line_gfx(code_q) && fglyph_q[0];
         end
      end
   end

   // CPU completion pulse and read data.
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         cpu_ack_q   <= 1'b0;
         cpu_rdata_q <= '0;
      end else begin
         cpu_ack_q <= (state_q == StCpu) && mem_ack_i;
         if (state_q == StCpu && mem_ack_i) cpu_rdata_q <= mem_rdata_i;
      end
   end

   assign glyph_o     = glyph_out_q;
   assign attr_o      = attr_out_q;
   assign col9_o      = col9_out_q;
   assign glyph_vld_o = vld_out_q;
   assign underrun_o  = underrun_q;
   assign cpu_ack_o   = cpu_ack_q;
   assign cpu_rdata_o = cpu_rdata_q;

endmodule

// File: tb/tb_vga_fetch_sched.sv
// Directed bench for vga_fetch_sched with a small latency-programmable memory.
module tb_vga_fetch_sched;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        mode8, char_stb, active, underrun_clr;
   logic [15:0] text_addr;
   logic [3:0]  row;
   logic        mem_req, mem_we, mem_ack;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic        cpu_req, cpu_we, cpu_ack;
   logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic [7:0]  glyph, attr;
   logic        col9, glyph_vld, underrun;

   int n_checks = 0;
   int n_errors = 0;
   int ack_delay;
   int fnt_delay;
   int wait_cnt;
   bit flag;

   always #5 clock = ~clock;

   vga_fetch_sched #(.ADDR_W(16), .FONT_BASE(16'hC000)) dut (
      .clock_i        (clock),
      .reset_ni       (reset_n),
      .mode8_i        (mode8),
      .char_stb_i     (char_stb),
      .active_i       (active),
      .text_addr_i    (text_addr),
      .row_i          (row),
      .mem_req_o      (mem_req),
      .mem_addr_o     (mem_addr),
      .mem_we_o       (mem_we),
      .mem_wdata_o    (mem_wdata),
      .mem_ack_i      (mem_ack),
      .mem_rdata_i    (mem_rdata),
      .cpu_req_i      (cpu_req),
      .cpu_we_i       (cpu_we),
      .cpu_addr_i     (cpu_addr),
      .cpu_wdata_i    (cpu_wdata),
      .cpu_ack_o      (cpu_ack),
      .cpu_rdata_o    (cpu_rdata),
      .glyph_o        (glyph),
      .attr_o         (attr),
      .col9_o         (col9),
      .glyph_vld_o    (glyph_vld),
      .underrun_o     (underrun),
      .underrun_clr_i (underrun_clr)
   );

   // Memory contents: text cells and the font rows they reference.
   function automatic logic [15:0] mem_word(input logic [15:0] a);
      case (a)
         16'h0010: return 16'h1F41;
         16'h0020: return 16'h07C4;
         16'h0030: return 16'h0741;
         16'hC413: return 16'h003C;
         16'hCC45: return 16'h00FF;
         16'hC415: return 16'h00FF;
         16'h1234: return 16'hBEEF;
         default:  return 16'h0000;
      endcase
   endfunction

   // Count cycles a request has been waiting; ack once the delay is reached.
   always @(posedge clock) begin
      if (!mem_req || mem_ack) wait_cnt <= 0;
      else wait_cnt <= wait_cnt + 1;
   end

   assign mem_ack   = mem_req && (wait_cnt >= ((mem_addr >= 16'hC000) ? fnt_delay : ack_delay));
   assign mem_rdata = mem_ack ? mem_word(mem_addr) : 16'h0000;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // One-cycle strobe; returns 1 ns after the edge that sampled it.
   task automatic strobe(input logic act, input logic [15:0] addr, input logic [3:0] r);
      char_stb  = 1'b1;
      active    = act;
      text_addr = addr;
      row       = r;
      @(posedge clock);
      #1;
      char_stb = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; mode8 = 1'b1; char_stb = 1'b0; active = 1'b0; underrun_clr = 1'b0;
      text_addr = '0; row = '0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      ack_delay = 0; fnt_delay = 0;
      idle(3);
      check("rst_mem_req", mem_req, 0);
      check("rst_glyph_vld", glyph_vld, 0);
      check("rst_underrun", underrun, 0);
      check("rst_cpu_ack", cpu_ack, 0);
      check("rst_mem_addr", mem_addr, 0);
      reset_n = 1'b1;
      idle(2);

      // Basic fetch, 8-dot mode
      strobe(1'b1, 16'h0010, 4'd3);
      check("t1_first_vld", glyph_vld, 1);
      check("t1_first_glyph", glyph, 0);
      idle(7);
      strobe(1'b1, 16'h0020, 4'd5);
      check("t1_glyph", glyph, 8'h3C);
      check("t1_attr", attr, 8'h1F);
      check("t1_col9", col9, 0);
      check("t1_vld", glyph_vld, 1);
      check("t1_underrun", underrun, 0);
      idle(1);
      check("t1_vld_once", glyph_vld, 0);
      idle(6);

      // Ninth column in 9-dot mode
      mode8 = 1'b0;
      strobe(1'b1, 16'h0030, 4'd5);
      check("t2_c4_glyph", glyph, 8'hFF);
      check("t2_c4_attr", attr, 8'h07);
      check("t2_c4_col9", col9, 1);
      idle(7);
      strobe(1'b1, 16'h0010, 4'd3);
      check("t2_41_glyph", glyph, 8'hFF);
      check("t2_41_col9", col9, 0);
      mode8 = 1'b1;
      idle(7);
      strobe(1'b0, 16'h0000, 4'd0);
      check("t2_inact_glyph", glyph, 0);
      idle(7);

      // CPU write with no video pending
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 16'hA5A5;
      idle(1);
      check("t3_wr_req", mem_req, 1);
      check("t3_wr_we", mem_we, 1);
      check("t3_wr_addr", mem_addr, 16'h1234);
      check("t3_wr_data", mem_wdata, 16'hA5A5);
      idle(1);
      check("t3_wr_ack", cpu_ack, 1);
      cpu_req = 1'b0; cpu_we = 1'b0;
      idle(1);
      check("t3_wr_ack_once", cpu_ack, 0);
      idle(2);

      // CPU read stalled 20 cycles with a strobe arriving mid-stall
      ack_delay = 20;
      cpu_req = 1'b1; cpu_addr = 16'h1234;
      idle(2);
      strobe(1'b1, 16'h0010, 4'd3);
      check("t3_stall_glyph", glyph, 0);
      check("t3_stall_underrun", underrun, 0);
      flag = 1'b0;
      for (int i = 0; i < 40 && !flag; i++) begin
         if (cpu_ack) flag = 1'b1;
         else idle(1);
      end
      check("t3_rd_ack_seen", flag, 1);
      check("t3_rd_data", cpu_rdata, 16'hBEEF);
      cpu_req = 1'b0; ack_delay = 0;
      idle(1);
      check("t3_txt_req", mem_req, 1);
      check("t3_txt_we", mem_we, 0);
      check("t3_txt_addr", mem_addr, 16'h0010);
      idle(5);
      ack_delay = 12;
      strobe(1'b1, 16'h0020, 4'd5);
      check("t3_after_glyph", glyph, 8'h3C);
      check("t3_after_attr", attr, 8'h1F);
      check("t3_after_underrun", underrun, 0);
      idle(7);

      // Underrun on a slow text fetch, clear, then recovery
      strobe(1'b1, 16'h0010, 4'd3);
      check("t4_urun_flag", underrun, 1);
      check("t4_urun_glyph", glyph, 0);
      check("t4_urun_attr", attr, 0);
      check("t4_urun_vld", glyph_vld, 1);
      ack_delay = 0;
      underrun_clr = 1'b1;
      idle(1);
      underrun_clr = 1'b0;
      check("t4_clr", underrun, 0);
      idle(6);
      strobe(1'b1, 16'h0020, 4'd5);
      check("t4_rec_glyph", glyph, 8'h3C);
      check("t4_rec_attr", attr, 8'h1F);
      check("t4_rec_underrun", underrun, 0);
      idle(7);

      // Inactive period: blank output, no memory traffic
      strobe(1'b0, 16'h0000, 4'd0);
      check("t5_glyph", glyph, 0);
      check("t5_attr", attr, 0);
      check("t5_vld", glyph_vld, 1);
      check("t5_underrun", underrun, 0);
      flag = 1'b0;
      repeat (7) begin
         if (mem_req) flag = 1'b1;
         idle(1);
      end
      check("t5_no_req", flag, 0);
      strobe(1'b1, 16'h0010, 4'd3);
      check("t5_next_glyph", glyph, 0);
      check("t5_next_underrun", underrun, 0);
      idle(7);

      // Reset while the font fetch is stalled
      fnt_delay = 20;
      strobe(1'b1, 16'h0020, 4'd5);
      check("t6_glyph", glyph, 8'h3C);
      flag = 1'b0;
      for (int i = 0; i < 10 && !flag; i++) begin
         if (mem_req && mem_addr == 16'hCC45) flag = 1'b1;
         else idle(1);
      end
      check("t6_in_fnt", flag, 1);
      #2;
      reset_n = 1'b0;
      #1;
      check("t6_rst_req", mem_req, 0);
      check("t6_rst_addr", mem_addr, 0);
      check("t6_rst_glyph", glyph, 0);
      check("t6_rst_attr", attr, 0);
      check("t6_rst_col9", col9, 0);
      check("t6_rst_vld", glyph_vld, 0);
      check("t6_rst_cpu_rdata", cpu_rdata, 0);
      check("t6_rst_ack", mem_ack, 0);
      idle(2);
      reset_n = 1'b1;
      idle(2);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
